i2c_slave_controller: RTL and testbench



---
 rtl/i2c_slave_controller.sv | 201 ++++++++++++++++++++
 tb/tb_i2c_slave_controller.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_controller.sv
// I2C target: oversampled SCL/SDA, START/STOP detect, 7-bit address match,
// RX bytes pushed to a FIFO, TX bytes popped from a show-ahead FIFO.
module i2c_slave_controller #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    output logic       read,
    input  logic [7:0] data_in,
    input  logic       empty_tx,
    output logic       write,
    output logic [7:0] data_out,
    output logic       busy,
    input  logic       scl,
    inout  wire        sda
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] ADDR      = 3'd1;
    localparam logic [2:0] ADDR_ACK  = 3'd2;
    localparam logic [2:0] RX_BYTE   = 3'd3;
    localparam logic [2:0] RX_ACK    = 3'd4;
    localparam logic [2:0] TX_BYTE   = 3'd5;
    localparam logic [2:0] TX_ACK    = 3'd6;
    localparam logic [2:0] WAIT_STOP = 3'd7;

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_d;
    logic                   sda_d;
    logic                   scl_s;
    logic                   sda_s;
    logic                   scl_rise;
    logic                   scl_fall;
    logic                   start_cond;
    logic                   stop_cond;

    logic [2:0] state;
    logic [2:0] bit_cnt;
    logic [6:0] shreg;
    logic [6:0] tx_sr;
    logic       rw;
    logic       byte_done;
    logic       sda_oe;
    logic [7:0] shift_in;
    logic [7:0] tx_next;

    assign sda = sda_oe ? 1'b0 : 1'bz;

    assign scl_s      = scl_sync[SYNC_STAGES-1];
    assign sda_s      = sda_sync[SYNC_STAGES-1];
    assign scl_rise   = scl_s & ~scl_d;
    assign scl_fall   = ~scl_s & scl_d;
    assign start_cond = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_cond  = scl_s & scl_d & ~sda_d & sda_s;

    assign shift_in = {shreg, sda_s};
    assign tx_next  = empty_tx ? 8'hFF : data_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            shreg     <= 7'd0;
            tx_sr     <= 7'h7F;
            rw        <= 1'b0;
            byte_done <= 1'b0;
            sda_oe    <= 1'b0;
            read      <= 1'b0;
            write     <= 1'b0;
            data_out  <= 8'h00;
            busy      <= 1'b0;
        end else begin
            read  <= 1'b0;
            write <= 1'b0;
            if (start_cond) begin
                state     <= ADDR;
                bit_cnt   <= 3'd0;
                shreg     <= 7'd0;
                byte_done <= 1'b0;
                sda_oe    <= 1'b0;
            end else if (stop_cond) begin
                state     <= IDLE;
                byte_done <= 1'b0;
                sda_oe    <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    ADDR: begin
                        if (byte_done) begin
                            if (scl_fall) begin
                                byte_done <= 1'b0;
                                sda_oe    <= 1'b1;
                                busy      <= 1'b1;
                                state     <= ADDR_ACK;
                            end
                        end else if (scl_rise) begin
                            shreg   <= shift_in[6:0];
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                rw <= sda_s;
                                if (shift_in[7:1] == SLAVE_ADDR) begin
                                    byte_done <= 1'b1;
                                end else begin
                                    busy  <= 1'b0;
                                    state <= WAIT_STOP;
                                end
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt <= 3'd0;
                            if (rw) begin
                                tx_sr  <= tx_next[6:0];
                                read   <= ~empty_tx;
                                sda_oe <= ~tx_next[7];
                                state  <= TX_BYTE;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= RX_BYTE;
                            end
                        end
                    end
                    RX_BYTE: begin
                        if (byte_done) begin
                            if (scl_fall) begin
                                byte_done <= 1'b0;
                                sda_oe    <= 1'b1;
                                state     <= RX_ACK;
                            end
                        end else if (scl_rise) begin
                            shreg   <= shift_in[6:0];
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                byte_done <= 1'b1;
                                write     <= 1'b1;
                                data_out  <= shift_in;
                            end
                        end
                    end
                    RX_ACK: begin
                        if (scl_fall) begin
                            sda_oe <= 1'b0;
                            state  <= RX_BYTE;
                        end
                    end
                    TX_BYTE: begin
                        if (scl_fall) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                sda_oe <= 1'b0;
                                state  <= TX_ACK;
                            end else begin
                                sda_oe <= ~tx_sr[6];
                                tx_sr  <= {tx_sr[5:0], 1'b1};
                            end
                        end
                    end
                    TX_ACK: begin
                        // Master ACK is latched on the rise; next byte loads on the fall.
                        if (byte_done) begin
                            if (scl_fall) begin
                                byte_done <= 1'b0;
                                bit_cnt   <= 3'd0;
                                tx_sr     <= tx_next[6:0];
                                read      <= ~empty_tx;
                                sda_oe    <= ~tx_next[7];
                                state     <= TX_BYTE;
                            end
                        end else if (scl_rise) begin
                            if (!sda_s) begin
                                byte_done <= 1'b1;
                            end else begin
                                state <= WAIT_STOP;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_controller.sv
// Bench for i2c_slave_controller: bit-banged master, RX scoreboard,
// TX FIFO model with expected-byte queue.
module tb_i2c_slave_controller;

    localparam int Q = 10;

    logic       clk;
    logic       reset;
    logic       read;
    logic [7:0] data_in;
    logic       empty_tx;
    logic       write;
    logic [7:0] data_out;
    logic       busy;
    logic       scl;
    logic       sda_low;
    wire        sda;

    int checks;
    int errors;
    int read_cnt;
    int write_cnt;

    logic [7:0] rx_q[$];
    logic [7:0] tx_fifo[$];
    logic [7:0] tx_exp_q[$];

    assign sda = sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_slave_controller #(
        .SLAVE_ADDR (7'h50),
        .SYNC_STAGES(2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .read    (read),
        .data_in (data_in),
        .empty_tx(empty_tx),
        .write   (write),
        .data_out(data_out),
        .busy    (busy),
        .scl     (scl),
        .sda     (sda)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (read === 1'b1) begin
            read_cnt++;
            if (tx_fifo.size() != 0) void'(tx_fifo.pop_front());
        end
    end

    always @(negedge clk) begin
        empty_tx = (tx_fifo.size() == 0);
        data_in  = empty_tx ? 8'h00 : tx_fifo[0];
    end

    always @(negedge clk) begin
        logic [7:0] exp;
        if (write === 1'b1) begin
            write_cnt++;
            checks++;
            if (rx_q.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected: data_out=%h, required no write", data_out);
            end else begin
                exp = rx_q.pop_front();
                if (data_out !== exp) begin
                    errors++;
                    $display("FAIL write_data: got %h, expected %h", data_out, exp);
                end
            end
        end
    end

    task automatic bus_wait(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_low = 1'b0;
        bus_wait(Q);
        scl = 1'b1;
        bus_wait(Q);
        sda_low = 1'b1;
        bus_wait(Q);
        scl = 1'b0;
        bus_wait(Q);
    endtask

    task automatic bus_stop();
        sda_low = 1'b1;
        bus_wait(Q);
        scl = 1'b1;
        bus_wait(Q);
        sda_low = 1'b0;
        bus_wait(Q);
    endtask

    task automatic send_bit(input logic b);
        sda_low = ~b;
        bus_wait(Q);
        scl = 1'b1;
        bus_wait(2 * Q);
        scl = 1'b0;
        bus_wait(Q);
    endtask

    task automatic recv_bit(output logic b);
        sda_low = 1'b0;
        bus_wait(Q);
        scl = 1'b1;
        bus_wait(Q);
        b = sda;
        bus_wait(Q);
        scl = 1'b0;
        bus_wait(Q);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(ack);
    endtask

    task automatic recv_byte(output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
    endtask

    task automatic check_ack(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: sda=%b, expected %b", name, got, exp);
        end
    endtask

    task automatic check_tx_byte(input string name, input logic [7:0] got);
        logic [7:0] exp;
        checks++;
        if (tx_exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: got %h, no byte expected", name, got);
        end else begin
            exp = tx_exp_q.pop_front();
            if (got !== exp) begin
                errors++;
                $display("FAIL %s: got %h, expected %h", name, got, exp);
            end
        end
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        scl     = 1'b1;
        sda_low = 1'b0;
        bus_wait(5);
        reset = 1'b0;
        bus_wait(5);
        checks++;
        if ({read, write, busy, data_out} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs: r=%b w=%b b=%b d=%h, expected zeros",
                     read, write, busy, data_out);
        end
        checks++;
        if (sda !== 1'b1) begin
            errors++;
            $display("FAIL reset_sda: sda=%b, expected 1", sda);
        end
    endtask

    task automatic test_write();
        logic ack;
        bus_start();
        send_byte(8'hA0, ack);
        check_ack("wr_addr_ack", ack, 1'b0);
        rx_q.push_back(8'hA5);
        send_byte(8'hA5, ack);
        check_ack("wr_data0_ack", ack, 1'b0);
        rx_q.push_back(8'h3C);
        send_byte(8'h3C, ack);
        check_ack("wr_data1_ack", ack, 1'b0);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL wr_busy_before_stop: busy=%b, expected 1", busy);
        end
        bus_stop();
        bus_wait(Q);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL wr_busy_after_stop: busy=%b, expected 0", busy);
        end
        checks++;
        if (rx_q.size() != 0 || write_cnt != 2) begin
            errors++;
            $display("FAIL wr_count: writes=%0d pending=%0d, expected 2 and 0",
                     write_cnt, rx_q.size());
        end
    endtask

    task automatic test_addr_mismatch();
        logic ack;
        int   w0;
        w0 = write_cnt;
        bus_start();
        send_byte(8'hA2, ack);
        check_ack("nack_addr", ack, 1'b1);
        send_byte(8'hFF, ack);
        check_ack("nack_data", ack, 1'b1);
        checks++;
        if (busy !== 1'b0 || write_cnt != w0) begin
            errors++;
            $display("FAIL nack_state: busy=%b writes=%0d, expected 0 and %0d",
                     busy, write_cnt, w0);
        end
        bus_stop();
    endtask

    task automatic test_read();
        logic       ack;
        logic [7:0] d;
        read_cnt = 0;
        tx_fifo  = '{8'h96, 8'h5A};
        tx_exp_q = '{8'h96, 8'h5A};
        bus_wait(2);
        bus_start();
        send_byte(8'hA1, ack);
        check_ack("rd_addr_ack", ack, 1'b0);
        recv_byte(d);
        check_tx_byte("rd_byte0", d);
        send_bit(1'b0);
        recv_byte(d);
        check_tx_byte("rd_byte1", d);
        send_bit(1'b1);
        sda_low = 1'b0;
        bus_wait(Q);
        checks++;
        if (read_cnt != 2 || busy !== 1'b1 || sda !== 1'b1) begin
            errors++;
            $display("FAIL rd_after_nack: reads=%0d busy=%b sda=%b, expected 2 1 1",
                     read_cnt, busy, sda);
        end
        bus_stop();
    endtask

    task automatic test_read_empty();
        logic       ack;
        logic [7:0] d;
        read_cnt = 0;
        tx_fifo.delete();
        tx_exp_q = '{8'hFF};
        bus_wait(2);
        bus_start();
        send_byte(8'hA1, ack);
        check_ack("empty_addr_ack", ack, 1'b0);
        recv_byte(d);
        check_tx_byte("empty_byte", d);
        send_bit(1'b1);
        checks++;
        if (read_cnt != 0) begin
            errors++;
            $display("FAIL empty_reads: reads=%0d, expected 0", read_cnt);
        end
        bus_stop();
    endtask

    task automatic test_repeated_start();
        logic       ack;
        logic [7:0] d;
        int         w0;
        w0       = write_cnt;
        read_cnt = 0;
        tx_fifo  = '{8'hC3};
        tx_exp_q = '{8'hC3};
        bus_start();
        send_byte(8'hA0, ack);
        check_ack("rs_wr_addr_ack", ack, 1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        bus_start();
        send_byte(8'hA1, ack);
        check_ack("rs_rd_addr_ack", ack, 1'b0);
        recv_byte(d);
        check_tx_byte("rs_byte", d);
        send_bit(1'b1);
        bus_stop();
        checks++;
        if (write_cnt != w0 || read_cnt != 1) begin
            errors++;
            $display("FAIL rs_counts: writes=%0d reads=%0d, expected %0d and 1",
                     write_cnt - w0, read_cnt, 0);
        end
    endtask

    task automatic test_reset_mid();
        logic ack;
        int   w0;
        w0 = write_cnt;
        bus_start();
        for (int i = 7; i >= 0; i--) send_bit(w0 >= 0 ? (8'hA0 >> i) & 1 : 1'b0);
        sda_low = 1'b0;
        bus_wait(Q);
        check_ack("rst_ack_driven", sda, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (sda !== 1'b1 || {read, write, busy, data_out} !== 11'd0) begin
            errors++;
            $display("FAIL rst_mid: sda=%b r=%b w=%b b=%b d=%h, expected 1 and zeros",
                     sda, read, write, busy, data_out);
        end
        bus_wait(Q);
        scl = 1'b1;
        bus_wait(2 * Q);
        scl = 1'b0;
        bus_wait(Q);
        send_byte(8'hA0, ack);
        check_ack("rst_no_start_ack", ack, 1'b1);
        checks++;
        if (busy !== 1'b0 || write_cnt != w0) begin
            errors++;
            $display("FAIL rst_no_start_state: busy=%b writes=%0d, expected 0 and %0d",
                     busy, write_cnt, w0);
        end
        bus_stop();
        bus_start();
        send_byte(8'hA0, ack);
        check_ack("rst_restart_ack", ack, 1'b0);
        bus_stop();
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        read_cnt  = 0;
        write_cnt = 0;
        scl       = 1'b1;
        sda_low   = 1'b0;
        reset     = 1'b1;
        test_reset();
        test_write();
        test_addr_mismatch();
        test_read();
        test_read_empty();
        test_repeated_start();
        test_reset_mid();
        bus_wait(Q);
        checks++;
        if (rx_q.size() != 0) begin
            errors++;
            $display("FAIL rx_leftover: %0d bytes never written, expected 0", rx_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
